// File: rtl/frost_share_aggregator_if.sv
// FROST DKG share stream: one (sender, share, commitment) message per handshake.
// The master is the dealer fabric; the slave is the per-node aggregator.
interface frost_share_aggregator_if #(
    parameter int ID_BITS     = 2,
    parameter int SCALAR_BITS = 252
) ();
    logic                   valid;
    logic                   ready;
    logic [ID_BITS-1:0]     sender;
    logic [SCALAR_BITS-1:0] share;
    logic [SCALAR_BITS-1:0] commit;

    modport master (
        output valid,
        output sender,
        output share,
        output commit,
        input  ready
    );

    modport slave (
        input  valid,
        input  sender,
        input  share,
        input  commit,
        output ready
    );
endinterface

// File: rtl/frost_share_aggregator.sv
// FROST DKG receive-side share aggregator: verifies, dedups and sums dealer shares.
// Optional macro FROST_AGG_TIMEOUT_EN bounds the collection phase by TIMEOUT_CYCLES.
module frost_share_aggregator #(
    parameter int NUM_NODES      = 4,
    parameter int THRESHOLD      = 2,
    parameter int SCALAR_BITS    = 252,
    parameter int ID_BITS        = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    frost_share_aggregator_if.slave i_bus,
    output logic [SCALAR_BITS-1:0] o_key_share,
    output logic [NUM_NODES-1:0]   o_recv_mask,
    output logic [NUM_NODES-1:0]   o_complaint_mask,
    output logic [7:0]             o_accepted_count,
    output logic [7:0]             o_reject_count,
    output logic                   o_done,
    output logic                   o_key_valid,
    output logic                   o_timed_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FINAL,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_ready;

    logic [SCALAR_BITS-1:0] r_key;
    logic [NUM_NODES-1:0]   r_recv;
    logic [NUM_NODES-1:0]   r_comp;
    logic [7:0]             r_acc;
    logic [7:0]             r_rej;
    logic                   r_done;
    logic                   r_key_valid;
    logic                   r_timed_out;

    logic                   w_clear;
    logic                   w_hs;
    logic                   w_bad_id;
    logic [NUM_NODES-1:0]   w_onehot;
    logic                   w_dup;
    logic                   w_commit_ok;
    logic                   w_do_acc;
    logic                   w_do_cmp;
    logic                   w_do_rej;
    logic [NUM_NODES-1:0]   w_recv_nxt;
    logic [NUM_NODES-1:0]   w_comp_nxt;
    logic                   w_all_heard;
    logic                   w_expire;

    // A new round may only be opened from an idle or finished aggregator.
    assign w_clear = i_start && (r_state == S_IDLE || r_state == S_DONE);

    // Message classification: bad ID, then duplicate, then commitment check.
    assign w_hs        = i_bus.valid && w_ready;
    assign w_bad_id    = (32'(i_bus.sender) >= NUM_NODES);
    assign w_onehot    = NUM_NODES'(1) << i_bus.sender;
    assign w_dup       = |(w_onehot & (r_recv | r_comp));
    assign w_commit_ok = (i_bus.commit == ~i_bus.share);
    assign w_do_acc    = w_hs && !w_bad_id && !w_dup && w_commit_ok;
    assign w_do_cmp    = w_hs && !w_bad_id && !w_dup && !w_commit_ok;
    assign w_do_rej    = w_hs && !w_do_acc;

    // Look-ahead masks so completion is seen in the handshake cycle itself.
    assign w_recv_nxt  = r_recv | (w_do_acc ? w_onehot : '0);
    assign w_comp_nxt  = r_comp | (w_do_cmp ? w_onehot : '0);
    assign w_all_heard = &(w_recv_nxt | w_comp_nxt);

`ifdef FROST_AGG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;

    assign w_expire = (r_state == S_COLLECT) &&
                      (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Collection-phase cycle counter, restarted with every round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_clear) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_COLLECT && !w_expire) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end
`else
    // Collection never expires; the parameter is kept so builds share one port list.
    assign w_expire = (TIMEOUT_CYCLES < 0);
`endif

    // Round state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream backpressure.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_ready = 1'b1;
                if (w_all_heard || w_expire) begin
                    w_state_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign i_bus.ready = w_ready;

    // Key accumulation and sender bookkeeping; the sum wraps mod 2^SCALAR_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_recv <= '0;
            r_comp <= '0;
            r_acc  <= '0;
        end else if (w_clear) begin
            r_key  <= '0;
            r_recv <= '0;
            r_comp <= '0;
            r_acc  <= '0;
        end else begin
            if (w_do_acc) begin
                r_key  <= r_key + i_bus.share;
                r_recv <= w_recv_nxt;
                r_acc  <= r_acc + 8'd1;
            end
            if (w_do_cmp) begin
                r_comp <= w_comp_nxt;
            end
        end
    end

    // Dropped-message counter, pinned at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rej <= '0;
        end else if (w_clear) begin
            r_rej <= '0;
        end else if (w_do_rej && r_rej != 8'hFF) begin
            r_rej <= r_rej + 8'd1;
        end
    end

    // Round outcome flags: verdict latched on the way out of FINAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (w_clear) begin
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == S_FINAL) begin
                r_done      <= 1'b1;
                r_key_valid <= (r_acc >= 8'(THRESHOLD)) && (r_comp == '0);
            end
            if (w_expire && !w_all_heard) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign o_key_share      = r_key;
    assign o_recv_mask      = r_recv;
    assign o_complaint_mask = r_comp;
    assign o_accepted_count = r_acc;
    assign o_reject_count   = r_rej;
    assign o_done           = r_done;
    assign o_key_valid      = r_key_valid;
    assign o_timed_out      = r_timed_out;

endmodule

// File: tb/tb_frost_share_aggregator.sv
// Bench for frost_share_aggregator: table-driven rounds with a scoreboard queue.
// Timeout rounds run only when FROST_AGG_TIMEOUT_EN is defined.
module tb_frost_share_aggregator;

    localparam int NN = 4;
    localparam int TH = 2;
    localparam int SB = 252;
    localparam int IB = 2;
    localparam int TO = 16;

    localparam int K_ACC = 0;
    localparam int K_DUP = 1;
    localparam int K_CMP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SB-1:0] o_key;
    logic [NN-1:0] o_recv;
    logic [NN-1:0] o_comp;
    logic [7:0]    o_acc;
    logic [7:0]    o_rej;
    logic          o_done;
    logic          o_kv;
    logic          o_to;

    always #5 clk = ~clk;

    frost_share_aggregator_if #(.ID_BITS(IB), .SCALAR_BITS(SB)) bus ();

    frost_share_aggregator #(
        .NUM_NODES(NN), .THRESHOLD(TH), .SCALAR_BITS(SB),
        .ID_BITS(IB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_bus           (bus),
        .o_key_share     (o_key),
        .o_recv_mask     (o_recv),
        .o_complaint_mask(o_comp),
        .o_accepted_count(o_acc),
        .o_reject_count  (o_rej),
        .o_done          (o_done),
        .o_key_valid     (o_kv),
        .o_timed_out     (o_to)
    );

    typedef struct {
        bit            first;
        logic [IB-1:0] snd;
        logic [SB-1:0] shr;
        logic [SB-1:0] cmt;
        int            kind;
        logic [SB-1:0] exp_key;
        bit            last;
        bit            exp_kv;
    } vec_t;

    typedef struct {
        logic [SB-1:0] key;
        logic [NN-1:0] recv;
        logic [NN-1:0] comp;
        logic [7:0]    acc;
        logic [7:0]    rej;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    logic [NN-1:0] m_recv;
    logic [NN-1:0] m_comp;
    logic [7:0]    m_acc;
    logic [7:0]    m_rej;

    int nvec = 0;
    int nfail = 0;

    function automatic vec_t mk(bit first, int snd, logic [SB-1:0] shr,
                                bit good, int kind, logic [SB-1:0] ek,
                                bit last, bit kv);
        vec_t v;
        v.first   = first;
        v.snd     = IB'(snd);
        v.shr     = shr;
        v.cmt     = good ? ~shr : shr;
        v.kind    = kind;
        v.exp_key = ek;
        v.last    = last;
        v.exp_kv  = kv;
        return v;
    endfunction

    task automatic chkw(input string nm, input logic [SB-1:0] act,
                        input logic [SB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0b, want %0b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chkw({nm, "_key"}, o_key, '0);
        chkw({nm, "_recv"}, SB'(o_recv), '0);
        chkw({nm, "_comp"}, SB'(o_comp), '0);
        chkw({nm, "_acc"}, SB'(o_acc), '0);
        chkw({nm, "_rej"}, SB'(o_rej), '0);
        chkb({nm, "_done"}, o_done, 1'b0);
        chkb({nm, "_kv"}, o_kv, 1'b0);
        chkb({nm, "_to"}, o_to, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_recv = '0;
        m_comp = '0;
        m_acc  = '0;
        m_rej  = '0;
        chkb("start_ready", bus.ready, 1'b1);
        chk_zero("start");
    endtask

    task automatic send_vec(input vec_t v);
        exp_t e;
        bus.valid  = 1'b1;
        bus.sender = v.snd;
        bus.share  = v.shr;
        bus.commit = v.cmt;
        case (v.kind)
            K_ACC: begin
                m_recv[v.snd] = 1'b1;
                m_acc = m_acc + 8'd1;
            end
            K_CMP: begin
                m_comp[v.snd] = 1'b1;
                m_rej = m_rej + 8'd1;
            end
            default: m_rej = m_rej + 8'd1;
        endcase
        e.key  = v.exp_key;
        e.recv = m_recv;
        e.comp = m_comp;
        e.acc  = m_acc;
        e.rej  = m_rej;
        sb_q.push_back(e);
        tick();
        bus.valid = 1'b0;
        if (sb_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL sb_empty: got 0 entries, want 1");
        end else begin
            e = sb_q.pop_front();
            chkw("key", o_key, e.key);
            chkw("recv", SB'(o_recv), SB'(e.recv));
            chkw("comp", SB'(o_comp), SB'(e.comp));
            chkw("acc", SB'(o_acc), SB'(e.acc));
            chkw("rej", SB'(o_rej), SB'(e.rej));
        end
    endtask

    task automatic finish_round(input logic [SB-1:0] key, input bit kv);
        chkb("final_ready", bus.ready, 1'b0);
        chkb("final_done", o_done, 1'b0);
        tick();
        chkb("done", o_done, 1'b1);
        chkb("key_valid", o_kv, kv);
        chkb("timed_out", o_to, 1'b0);
        chkb("done_ready", bus.ready, 1'b0);
        bus.valid  = 1'b1;
        bus.sender = '0;
        bus.share  = SB'(1);
        bus.commit = ~SB'(1);
        tick();
        bus.valid = 1'b0;
        tick();
        chkb("hold_done", o_done, 1'b1);
        chkw("hold_key", o_key, key);
        chkw("hold_acc", SB'(o_acc), SB'(m_acc));
    endtask

    logic [SB-1:0] ones;

    initial begin
        ones = '1;
        bus.valid  = 1'b0;
        bus.sender = '0;
        bus.share  = '0;
        bus.commit = '0;

        // Four clean shares 1..4.
        tbl.push_back(mk(1, 0, SB'(1), 1, K_ACC, SB'(1), 0, 0));
        tbl.push_back(mk(0, 1, SB'(2), 1, K_ACC, SB'(3), 0, 0));
        tbl.push_back(mk(0, 2, SB'(3), 1, K_ACC, SB'(6), 0, 0));
        tbl.push_back(mk(0, 3, SB'(4), 1, K_ACC, SB'(10), 1, 1));
        // Duplicate sender 2 is dropped and not summed.
        tbl.push_back(mk(1, 2, SB'(5), 1, K_ACC, SB'(5), 0, 0));
        tbl.push_back(mk(0, 2, SB'(5), 1, K_DUP, SB'(5), 0, 0));
        tbl.push_back(mk(0, 0, SB'(7), 1, K_ACC, SB'(12), 0, 0));
        tbl.push_back(mk(0, 1, SB'(11), 1, K_ACC, SB'(23), 0, 0));
        tbl.push_back(mk(0, 3, SB'(13), 1, K_ACC, SB'(36), 1, 1));
        // Sender 1 fails the commitment check.
        tbl.push_back(mk(1, 1, SB'(9), 0, K_CMP, SB'(0), 0, 0));
        tbl.push_back(mk(0, 0, SB'(4), 1, K_ACC, SB'(4), 0, 0));
        tbl.push_back(mk(0, 2, SB'(6), 1, K_ACC, SB'(10), 0, 0));
        tbl.push_back(mk(0, 3, SB'(8), 1, K_ACC, SB'(18), 1, 0));
        // Modular wrap of the running sum.
        tbl.push_back(mk(1, 0, ones, 1, K_ACC, ones, 0, 0));
        tbl.push_back(mk(0, 1, SB'(2), 1, K_ACC, SB'(1), 0, 0));
        tbl.push_back(mk(0, 2, SB'(3), 1, K_ACC, SB'(4), 0, 0));
        tbl.push_back(mk(0, 3, SB'(0), 1, K_ACC, SB'(4), 1, 1));

        #2;
        chkb("rst_ready", bus.ready, 1'b0);
        chk_zero("rst");
        tick();
        rst_n = 1'b1;
        tick();
        chkb("idle_ready", bus.ready, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].first) do_start();
            send_vec(tbl[i]);
            if (tbl[i].last) finish_round(tbl[i].exp_key, tbl[i].exp_kv);
        end

        // Reset in the middle of a round wipes everything.
        do_start();
        send_vec(mk(0, 0, SB'(5), 1, K_ACC, SB'(5), 0, 0));
        send_vec(mk(0, 1, SB'(6), 1, K_ACC, SB'(11), 0, 0));
        rst_n = 1'b0;
        #2;
        chk_zero("midrst");
        tick();
        chk_zero("midrst_edge");
        chkb("midrst_ready", bus.ready, 1'b0);
        rst_n = 1'b1;
        tick();
        // Fresh round; start raised mid-collection is ignored.
        do_start();
        send_vec(mk(0, 0, SB'(20), 1, K_ACC, SB'(20), 0, 0));
        start = 1'b1;
        send_vec(mk(0, 1, SB'(21), 1, K_ACC, SB'(41), 0, 0));
        start = 1'b0;
        send_vec(mk(0, 2, SB'(22), 1, K_ACC, SB'(63), 0, 0));
        send_vec(mk(0, 3, SB'(23), 1, K_ACC, SB'(86), 0, 0));
        finish_round(SB'(86), 1);

`ifdef FROST_AGG_TIMEOUT_EN
        // Two shares then timeout: done 18 cycles after start.
        do_start();
        send_vec(mk(0, 0, SB'(3), 1, K_ACC, SB'(3), 0, 0));
        send_vec(mk(0, 1, SB'(4), 1, K_ACC, SB'(7), 0, 0));
        for (int i = 0; i < 14; i++) tick();
        chkb("to2_early_done", o_done, 1'b0);
        tick();
        chkb("to2_done", o_done, 1'b1);
        chkb("to2_timed_out", o_to, 1'b1);
        chkb("to2_kv", o_kv, 1'b1);
        chkw("to2_key", o_key, SB'(7));
        // One share only: below threshold.
        do_start();
        send_vec(mk(0, 2, SB'(9), 1, K_ACC, SB'(9), 0, 0));
        for (int i = 0; i < 15; i++) tick();
        chkb("to1_early_done", o_done, 1'b0);
        tick();
        chkb("to1_done", o_done, 1'b1);
        chkb("to1_timed_out", o_to, 1'b1);
        chkb("to1_kv", o_kv, 1'b0);
`else
        // Without the timeout, a partial round never finishes.
        do_start();
        send_vec(mk(0, 0, SB'(3), 1, K_ACC, SB'(3), 0, 0));
        for (int i = 0; i < 40; i++) tick();
        chkb("notmo_done", o_done, 1'b0);
        chkb("notmo_to", o_to, 1'b0);
        chkb("notmo_ready", bus.ready, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
